// File: rtl/multi_pulse_detect_pkg.sv
// multi_pulse_detect_pkg: edge-mode encodings shared by the detector and its channels
package multi_pulse_detect_pkg;
    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;
endpackage

// File: rtl/multi_pulse_detect_pulse_chan.sv
// pulse_chan: one channel of synchroniser, glitch filter, edge detector, stretcher and event counter
module pulse_chan
    import multi_pulse_detect_pkg::*;
#(
    parameter int SYNC_STAGE = 2,
    parameter int FILT_W     = 4,
    parameter int STRETCH_W  = 4,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic [1:0]           mode,
    input  logic [FILT_W-1:0]    min_width,
    input  logic [STRETCH_W-1:0] stretch_len,
    input  logic                 cnt_clr,
    output logic                 ev,
    output logic                 pulse,
    output logic [CNT_W-1:0]     cnt
);
    logic [SYNC_STAGE-1:0] s;
    logic [FILT_W-1:0]     fcnt;
    logic [STRETCH_W-1:0]  scnt;
    logic                  filt_lvl, filt_prev, sync_out, rise, fall, rise_en, fall_en;

    assign sync_out = s[SYNC_STAGE-1];
    assign rise     = filt_lvl & ~filt_prev;
    assign fall     = ~filt_lvl & filt_prev;
    assign rise_en  = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    assign fall_en  = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    assign ev       = (rise_en & rise) | (fall_en & fall);

    // Synchronise the raw input and accept a new level only after it holds min_width+1 cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            fcnt      <= '0;
            filt_lvl  <= 1'b0;
            filt_prev <= 1'b0;
        end else begin
            s         <= (s << 1) | SYNC_STAGE'(din);
            filt_prev <= filt_lvl;
            if (sync_out == filt_lvl) begin
                fcnt <= '0;
            end else if (fcnt >= min_width) begin
                filt_lvl <= sync_out;
                fcnt     <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Stretch each event into a retriggerable pulse and count events with saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt  <= '0;
            pulse <= 1'b0;
            cnt   <= '0;
        end else begin
            if (ev) begin
                scnt  <= stretch_len;
                pulse <= 1'b1;
            end else if (scnt != '0) begin
                scnt  <= scnt - 1'b1;
                pulse <= 1'b1;
            end else begin
                pulse <= 1'b0;
            end
            cnt <= cnt_clr ? CNT_W'(ev) : (ev && cnt != '1) ? cnt + 1'b1 : cnt;
        end
    end
endmodule

// File: rtl/multi_pulse_detect.sv
// multi_pulse_detect: multi-channel filtered edge detector with stretched pulses and event counters
module multi_pulse_detect
    import multi_pulse_detect_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int SYNC_STAGE = 2,
    parameter int FILT_W     = 4,
    parameter int STRETCH_W  = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH_NUM-1:0]       data_in,
    input  logic [2*CH_NUM-1:0]     edge_mode,
    input  logic [FILT_W-1:0]       min_width,
    input  logic [STRETCH_W-1:0]    stretch_len,
    input  logic [CH_NUM-1:0]       cnt_clr,
    output logic [CH_NUM-1:0]       pulse_out,
    output logic [CH_NUM*CNT_W-1:0] event_cnt,
    output logic                    event_any
);
    logic [CH_NUM-1:0] ev;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        pulse_chan #(
            .SYNC_STAGE(SYNC_STAGE),
            .FILT_W    (FILT_W),
            .STRETCH_W (STRETCH_W),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .din        (data_in[i]),
            .mode       (edge_mode[2*i +: 2]),
            .min_width  (min_width),
            .stretch_len(stretch_len),
            .cnt_clr    (cnt_clr[i]),
            .ev         (ev[i]),
            .pulse      (pulse_out[i]),
            .cnt        (event_cnt[CNT_W*i +: CNT_W])
        );
    end

    // One-cycle strobe whenever any channel qualifies an event
    always_ff @(posedge clk) begin
        if (rst) event_any <= 1'b0;
        else     event_any <= |ev;
    end
endmodule

// File: tb/tb_multi_pulse_detect.sv
// tb_multi_pulse_detect: directed table and sequence checks for multi_pulse_detect
module tb_multi_pulse_detect;
    import multi_pulse_detect_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  data_in;
    logic [7:0]  edge_mode;
    logic [3:0]  min_width;
    logic [3:0]  stretch_len;
    logic [3:0]  cnt_clr;
    logic [3:0]  pulse_out;
    logic [31:0] event_cnt;
    logic        event_any;
    logic [3:0]  p_or;
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic       din;
        logic       p;
        logic       a;
        logic [7:0] c;
    } vec_t;
    vec_t vecs[10];

    multi_pulse_detect dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .edge_mode  (edge_mode),
        .min_width  (min_width),
        .stretch_len(stretch_len),
        .cnt_clr    (cnt_clr),
        .pulse_out  (pulse_out),
        .event_cnt  (event_cnt),
        .event_any  (event_any)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run(input int n, input int ch, output int evs, output int highs, output int segs);
        logic prev;
        evs = 0;
        highs = 0;
        segs = 0;
        prev = pulse_out[ch];
        for (int k = 0; k < n; k++) begin
            tick();
            p_or |= pulse_out;
            if (event_any) evs++;
            if (pulse_out[ch]) highs++;
            if (pulse_out[ch] && !prev) segs++;
            prev = pulse_out[ch];
        end
    endtask

    initial begin
        int e1, h1, s1, e2, h2, s2, e3, h3, s3;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 8'd1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'd1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'd1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'd1};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 8'd1};
        p_or = '0;
        rst = 1'b1;
        data_in = '0;
        edge_mode = {EDGE_OFF, EDGE_OFF, EDGE_OFF, EDGE_RISE};
        min_width = 4'd0;
        stretch_len = 4'd0;
        cnt_clr = '0;
        tick();
        tick();
        chk("reset pulse_out", 32'(pulse_out), 32'd0);
        chk("reset event_any", 32'(event_any), 32'd0);
        chk("reset event_cnt", event_cnt, 32'd0);
        rst = 1'b0;

        // basic latency with table: rise on ch0
        for (int r = 0; r < 10; r++) begin
            data_in[0] = vecs[r].din;
            tick();
            chk($sformatf("t1 r%0d pulse0", r), 32'(pulse_out[0]), 32'(vecs[r].p));
            chk($sformatf("t1 r%0d any", r), 32'(event_any), 32'(vecs[r].a));
            chk($sformatf("t1 r%0d cnt0", r), 32'(event_cnt[7:0]), 32'(vecs[r].c));
        end

        // glitch filter on ch1
        edge_mode = {EDGE_OFF, EDGE_OFF, EDGE_RISE, EDGE_OFF};
        min_width = 4'd3;
        data_in[1] = 1'b1;
        tick(); tick(); tick();
        data_in[1] = 1'b0;
        run(12, 1, e1, h1, s1);
        chk("t2 glitch events", 32'(e1), 32'd0);
        chk("t2 glitch cnt1", 32'(event_cnt[15:8]), 32'd0);
        data_in[1] = 1'b1;
        run(5, 1, e1, h1, s1);
        data_in[1] = 1'b0;
        run(15, 1, e2, h2, s2);
        chk("t2 valid events", 32'(e1 + e2), 32'd1);
        chk("t2 valid cnt1", 32'(event_cnt[15:8]), 32'd1);

        // both edges on ch2 with stretch 5
        edge_mode = {EDGE_OFF, EDGE_BOTH, EDGE_OFF, EDGE_OFF};
        min_width = 4'd0;
        stretch_len = 4'd5;
        data_in[2] = 1'b1;
        run(20, 2, e1, h1, s1);
        data_in[2] = 1'b0;
        run(20, 2, e2, h2, s2);
        chk("t3 events", 32'(e1 + e2), 32'd2);
        chk("t3 pulse cycles", 32'(h1 + h2), 32'd12);
        chk("t3 pulse segments", 32'(s1 + s2), 32'd2);
        chk("t3 cnt2", 32'(event_cnt[23:16]), 32'd2);

        // retrigger on ch3 every 4 cycles
        edge_mode = {EDGE_RISE, EDGE_OFF, EDGE_OFF, EDGE_OFF};
        stretch_len = 4'd7;
        e3 = 0; h3 = 0; s3 = 0;
        for (int r = 0; r < 3; r++) begin
            data_in[3] = 1'b1;
            run(2, 3, e1, h1, s1);
            e3 += e1; h3 += h1; s3 += s1;
            data_in[3] = 1'b0;
            run(2, 3, e1, h1, s1);
            e3 += e1; h3 += h1; s3 += s1;
        end
        run(20, 3, e1, h1, s1);
        e3 += e1; h3 += h1; s3 += s1;
        chk("t4 events", 32'(e3), 32'd3);
        chk("t4 pulse cycles", 32'(h3), 32'd16);
        chk("t4 pulse segments", 32'(s3), 32'd1);
        chk("t4 cnt3", 32'(event_cnt[31:24]), 32'd3);

        // saturation and clear on ch0
        edge_mode = {EDGE_OFF, EDGE_OFF, EDGE_OFF, EDGE_BOTH};
        stretch_len = 4'd0;
        for (int r = 0; r < 300; r++) begin
            data_in[0] = ~data_in[0];
            tick();
        end
        chk("t5 saturated", 32'(event_cnt[7:0]), 32'd255);
        chk("t5 any while toggling", 32'(event_any), 32'd1);
        cnt_clr = 4'b0001;
        data_in[0] = ~data_in[0];
        tick();
        cnt_clr = '0;
        chk("t5 clr with event", 32'(event_cnt[7:0]), 32'd1);
        run(8, 0, e1, h1, s1);
        cnt_clr = 4'b0001;
        tick();
        cnt_clr = '0;
        chk("t5 clr alone", 32'(event_cnt[7:0]), 32'd0);

        // reset mid-stretch, then per-mode behaviour after release
        edge_mode = {EDGE_OFF, EDGE_FALL, EDGE_BOTH, EDGE_RISE};
        stretch_len = 4'd15;
        data_in = '0;
        run(6, 0, e1, h1, s1);
        data_in = 4'hF;
        run(6, 0, e1, h1, s1);
        chk("t6 mid-stretch", 32'(pulse_out[1:0]), 32'h3);
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("t6 rst pulse_out", 32'(pulse_out), 32'd0);
            chk("t6 rst event_any", 32'(event_any), 32'd0);
            chk("t6 rst event_cnt", event_cnt, 32'd0);
        end
        rst = 1'b0;
        p_or = '0;
        run(25, 0, e1, h1, s1);
        chk("t6 strobes", 32'(e1), 32'd1);
        chk("t6 counts", event_cnt, 32'h0000_0101);
        chk("t6 active pulses", 32'(p_or), 32'h3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
